// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: up/down modulo-MODULUS counter with load, enable,
// wrap/saturate limit handling, a terminal-count pulse, and a sequential
// double-dabble converter presenting the count as packed BCD digits.
module bcd_updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 200,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = BW + WIDTH;
  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned IW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 1);
  localparam logic [XW-1:0]    MOD_X    = XW'(MODULUS);
  localparam logic [IW-1:0]    LAST_IT  = IW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  // Counter state
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;

  // Converter state
  state_t           state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [SW-1:0]    sh_q, sh_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic [SW-1:0]    dabble_step;

  // Counter next state: load beats enable; limits either wrap or hold
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = (XW'(d) >= MOD_X) ? MAX_Q : d;
    end else if (en) begin
      if (up) begin
        if (q_q == MAX_Q) begin
          tc_d = 1'b1;
          if (SATURATE == 0) q_d = '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          tc_d = 1'b1;
          if (SATURATE == 0) q_d = MAX_Q;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
  always_comb begin
    logic [SW-1:0] adj;
    adj = sh_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (adj[WIDTH+4*k +: 4] >= 4'd5) begin
        adj[WIDTH+4*k +: 4] = adj[WIDTH+4*k +: 4] + 4'd3;
      end
    end
    dabble_step = adj << 1;
  end

  // Converter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Converter next state: start on a new count, finish after WIDTH iterations
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (q_q != snap_q) state_d = CONV;
      CONV:    if (iter_q == LAST_IT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Converter datapath: snapshot/preload in IDLE, iterate and publish in CONV
  always_comb begin
    snap_d      = snap_q;
    sh_d        = sh_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (q_q != snap_q) begin
          snap_d = q_q;
          sh_d   = SW'(q_q);
          iter_d = '0;
        end
      end
      CONV: begin
        sh_d   = dabble_step;
        iter_d = iter_q + IW'(1);
        if (iter_q == LAST_IT) begin
          bcd_d       = dabble_step[SW-1 -: BW];
          bcd_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Converter datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q      <= '0;
      sh_q        <= '0;
      iter_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      sh_q        <= sh_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign q         = q_q;
  assign tc        = tc_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = (state_q == CONV);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: one wrapping and one saturating instance
// share stimulus; a decimal-arithmetic reference model predicts all outputs.
module tb_bcd_updown_counter;

  localparam int W = 8;
  localparam int M = 200;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [7:0] d;

  logic [7:0]  dq     [2];
  logic        dtc    [2];
  logic [11:0] dbcd   [2];
  logic        dvalid [2];
  logic        dbusy  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = wrap, 1 = saturate
  int   mq [2], mtc [2], mval [2], msnap [2], mleft [2];
  logic [11:0] mbcd [2];
  bit   seen [256];

  always #5 clk = ~clk;

  bcd_updown_counter #(.WIDTH(8), .MODULUS(200), .DIGITS(3), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
    .q(dq[0]), .tc(dtc[0]), .bcd(dbcd[0]), .bcd_valid(dvalid[0]), .busy(dbusy[0])
  );

  bcd_updown_counter #(.WIDTH(8), .MODULUS(200), .DIGITS(3), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
    .q(dq[1]), .tc(dtc[1]), .bcd(dbcd[1]), .bcd_valid(dvalid[1]), .busy(dbusy[1])
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int t;
    t = v;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Advance one clock and move the model by the same edge
  task automatic step();
    logic r, l, e, u;
    int   dv;
    r = reset; l = load; e = en; u = up; dv = int'(d);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mq[i] = 0; mtc[i] = 0; mbcd[i] = '0; mval[i] = 0; msnap[i] = 0; mleft[i] = 0;
      end else begin
        mval[i] = 0;
        if (mleft[i] > 0) begin
          mleft[i]--;
          if (mleft[i] == 0) begin
            mbcd[i] = to_bcd(msnap[i]);
            mval[i] = 1;
          end
        end else if (mq[i] != msnap[i]) begin
          msnap[i] = mq[i];
          mleft[i] = W;
        end
        mtc[i] = 0;
        if (l) begin
          mq[i] = (dv >= M) ? M - 1 : dv;
        end else if (e) begin
          if (u) begin
            if (mq[i] == M - 1) begin
              mtc[i] = 1;
              if (i == 0) mq[i] = 0;
            end else mq[i] = mq[i] + 1;
          end else begin
            if (mq[i] == 0) begin
              mtc[i] = 1;
              if (i == 0) mq[i] = M - 1;
            end else mq[i] = mq[i] - 1;
          end
        end
      end
    end
    seen[mq[0]] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (dq[i] !== 8'd0 || dtc[i] !== 1'b0 || dbcd[i] !== 12'h000 ||
          dvalid[i] !== 1'b0 || dbusy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: q=%0d tc=%b bcd=%h valid=%b busy=%b, required all zero",
                 i, dq[i], dtc[i], dbcd[i], dvalid[i], dbusy[i]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      step();
      n_tests++;
      if (dq[0] !== 8'd0 || dbcd[0] !== 12'h000 || dbusy[0] !== 1'b0 || dvalid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold c=%0d: q=%0d bcd=%h busy=%b valid=%b, required 0/000/0/0",
                 c, dq[0], dbcd[0], dbusy[0], dvalid[0]);
      end
    end
  endtask

  task automatic test_load_convert();
    int pulses, pulse_at;
    load = 1'b1; d = 8'd137;
    step();
    load = 1'b0;
    n_tests++;
    if (dq[0] !== 8'd137 || dtc[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load137: q=%0d tc=%b, required 137/0", dq[0], dtc[0]);
    end
    pulses = 0; pulse_at = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_tests++;
      if (dbusy[0] !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL busy137 c=%0d: busy=%b, required %b", c, dbusy[0], (c >= 1 && c <= 8));
      end
      if (dvalid[0] === 1'b1) begin
        pulses++;
        pulse_at = c;
      end
    end
    n_tests++;
    if (pulses != 1 || pulse_at != 9 || dbcd[0] !== 12'h137) begin
      n_fail++;
      $display("FAIL conv137: pulses=%0d at=%0d bcd=%h, required 1 at 9 bcd=137",
               pulses, pulse_at, dbcd[0]);
    end
  endtask

  task automatic test_wrap();
    int exp_q [3] = '{199, 0, 1};
    int exp_t [3] = '{0, 1, 0};
    load = 1'b1; d = 8'd198;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (dq[0] !== 8'(exp_q[c]) || dtc[0] !== 1'(exp_t[c])) begin
        n_fail++;
        $display("FAIL wrap_up c=%0d: q=%0d tc=%b, required %0d/%0d",
                 c, dq[0], dtc[0], exp_q[c], exp_t[c]);
      end
    end
    en = 1'b0; load = 1'b1; d = 8'd0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    en = 1'b0;
    n_tests++;
    if (dq[0] !== 8'd199 || dtc[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down: q=%0d tc=%b, required 199/1", dq[0], dtc[0]);
    end
    step();
    n_tests++;
    if (dtc[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_tc_clear: tc=%b, required 0", dtc[0]);
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; d = 8'd250; en = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    n_tests++;
    if (dq[1] !== 8'd199 || dtc[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clamp: q=%0d tc=%b, required 199/0", dq[1], dtc[1]);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if (dq[1] !== 8'd199 || dtc[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_up c=%0d: q=%0d tc=%b, required 199/1", c, dq[1], dtc[1]);
      end
    end
    en = 1'b0; load = 1'b1; d = 8'd0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    en = 1'b0;
    n_tests++;
    if (dq[1] !== 8'd0 || dtc[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_down: q=%0d tc=%b, required 0/1", dq[1], dtc[1]);
    end
  endtask

  task automatic test_continuous();
    bit done;
    load = 1'b1; d = 8'd0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      n_tests++;
      if (dq[0] !== 8'(mq[0]) || dbcd[0] !== mbcd[0] || dvalid[0] !== 1'(mval[0]) ||
          !seen[from_bcd(dbcd[0]) % 256]) begin
        n_fail++;
        $display("FAIL cont c=%0d: q=%0d bcd=%h valid=%b, required %0d/%h/%0d",
                 c, dq[0], dbcd[0], dvalid[0], mq[0], mbcd[0], mval[0]);
      end
    end
    en = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 2 * (W + 1) && !done; c++) begin
      step();
      if (dbcd[0] === to_bcd(mq[0]) && dbusy[0] === 1'b0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL converge: bcd=%h, required %h within %0d cycles", dbcd[0], to_bcd(mq[0]), 2 * (W + 1));
    end
  endtask

  task automatic test_reset_midconv();
    int pulses;
    load = 1'b1; d = 8'd155;
    step();
    load = 1'b0;
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (dq[0] !== 8'd0 || dbcd[0] !== 12'h000 || dbusy[0] !== 1'b0 || dvalid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: q=%0d bcd=%h busy=%b valid=%b, required 0/000/0/0",
               dq[0], dbcd[0], dbusy[0], dvalid[0]);
    end
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (dvalid[0] === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_pulse: pulses=%0d, required 0", pulses);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = 1'($urandom);
      d     = 8'($urandom_range(0, 255));
      step();
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (dq[i] !== 8'(mq[i]) || dtc[i] !== 1'(mtc[i]) || dbcd[i] !== mbcd[i] ||
            dvalid[i] !== 1'(mval[i]) || dbusy[i] !== (mleft[i] > 0)) begin
          n_fail++;
          $display("FAIL rand[%0d] c=%0d: q=%0d tc=%b bcd=%h v=%b busy=%b, required %0d/%0d/%h/%0d/%0d",
                   i, c, dq[i], dtc[i], dbcd[i], dvalid[i], dbusy[i],
                   mq[i], mtc[i], mbcd[i], mval[i], (mleft[i] > 0));
        end
      end
    end
    reset = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mtc[i] = 0; mbcd[i] = '0; mval[i] = 0; msnap[i] = 0; mleft[i] = 0;
    end
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[0] = 1'b1;
    test_reset();
    test_load_convert();
    test_wrap();
    test_saturate();
    test_continuous();
    test_reset_midconv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
